pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// fetch misses and data-memory freezes, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        D_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] REM_INIT = 2'(LOAD_STALL - 1);

    state_t     state;
    state_t     ret_state;
    state_t     eff_state;
    logic [1:0] remaining;
    logic       lu_hazard;
    logic       branch_flush;

    assign lu_hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // Leaving D_WAIT behaves exactly like the state that was interrupted.
    assign eff_state = (state == D_WAIT) ? ret_state : state;

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (!dmem_ready) begin
            pc_write = 1'b0;
        end else if (eff_state == LU_STALL || lu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            branch_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            remaining <= 2'd0;
        end else if (!dmem_ready) begin
            if (state != D_WAIT) begin
                state     <= D_WAIT;
                ret_state <= state;
            end
        end else if (eff_state == LU_STALL) begin
            if (remaining <= 2'd1) begin
                state     <= RUN;
                remaining <= 2'd0;
            end else begin
                state     <= LU_STALL;
                remaining <= remaining - 2'd1;
            end
        end else if (lu_hazard && LOAD_STALL > 1) begin
            state     <= LU_STALL;
            remaining <= REM_INIT;
        end else begin
            state <= RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
